// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: lets N drawing engines share the one VGA adapter pixel port.
// An engine owns the port for a whole burst, which ends on done, on req drop,
// or when the hold counter expires. At least one idle cycle separates bursts.
// Every output toward the adapter is a register.
module vga_draw_arbiter #(
    parameter int N_CH     = 3,
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int CW       = 3,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 2**17 - 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [N_CH-1:0]      req,
    input  logic [N_CH-1:0]      done,
    input  logic [N_CH-1:0]      plot_in,
    input  logic [N_CH*XW-1:0]   x_in,
    input  logic [N_CH*YW-1:0]   y_in,
    input  logic [N_CH*CW-1:0]   color_in,
    output logic [N_CH-1:0]      grant,
    output logic                 busy,
    output logic                 plot,
    output logic [XW-1:0]        X,
    output logic [YW-1:0]        Y,
    output logic [CW-1:0]        color,
    output logic                 timeout
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n;
    logic [IW-1:0]   rr_ptr, rr_n;
    logic [HW-1:0]   hold, hold_n;
    logic [N_CH-1:0] grant_n;
    logic            plot_n, timeout_n;
    logic [XW-1:0]   x_n;
    logic [YW-1:0]   y_n;
    logic [CW-1:0]   c_n;

    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            expire, release_now;

    assign busy = (state == BUSY);

    // Winner search: scan from index 0 (fixed) or from the rr pointer (round-robin).
    always_comb begin
        int cand;
        cand      = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (RR_MODE != 0) cand = (int'(rr_ptr) + k) % N_CH;
            else              cand = k;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // Release happens on the owner's done, the owner's req drop, or counter expiry.
    always_comb begin
        expire      = (MAX_HOLD != 0) && (hold == HOLD_LAST);
        release_now = done[owner] || !req[owner] || expire;
    end

    // Next-state and next-output logic; outputs default to holding, plot and timeout to 0.
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        rr_n      = rr_ptr;
        hold_n    = hold;
        grant_n   = grant;
        plot_n    = 1'b0;
        timeout_n = 1'b0;
        x_n       = X;
        y_n       = Y;
        c_n       = color;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n          = BUSY;
                    owner_n          = win_idx;
                    hold_n           = '0;
                    grant_n          = '0;
                    grant_n[win_idx] = 1'b1;
                end
            end
            BUSY: begin
                // The pixel presented in the release cycle is still forwarded.
                plot_n = plot_in[owner] & req[owner];
                x_n    = x_in[int'(owner)*XW +: XW];
                y_n    = y_in[int'(owner)*YW +: YW];
                c_n    = color_in[int'(owner)*CW +: CW];
                if (hold != '1) hold_n = hold + 1'b1;
                if (release_now) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    timeout_n = expire && req[owner] && !done[owner];
                    if (int'(owner) == N_CH - 1) rr_n = '0;
                    else                         rr_n = owner + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and adapter-facing registers; everything clears on reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            hold    <= '0;
            grant   <= '0;
            plot    <= 1'b0;
            timeout <= 1'b0;
            X       <= '0;
            Y       <= '0;
            color   <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            rr_ptr  <= rr_n;
            hold    <= hold_n;
            grant   <= grant_n;
            plot    <= plot_n;
            timeout <= timeout_n;
            X       <= x_n;
            Y       <= y_n;
            color   <= c_n;
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: a fixed-priority instance and a
// round-robin instance, both with a short hold limit of 8 cycles.
module tb_vga_draw_arbiter;

    localparam int N  = 3;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic            clock;
    logic            resetn;
    logic [N-1:0]    req, done, plot_in;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] color_in;
    logic [N-1:0]    grant;
    logic            busy, plot, timeout;
    logic [XW-1:0]   X;
    logic [YW-1:0]   Y;
    logic [CW-1:0]   color;

    logic [N-1:0]    rr_req, rr_done;
    logic [N-1:0]    rr_grant;
    logic            rr_busy, rr_plot, rr_timeout;
    logic [XW-1:0]   rr_X;
    logic [YW-1:0]   rr_Y;
    logic [CW-1:0]   rr_color;

    int checks = 0;
    int errors = 0;

    vga_draw_arbiter #(.N_CH(N), .XW(XW), .YW(YW), .CW(CW), .RR_MODE(0), .MAX_HOLD(8)) dut (
        .clock(clock), .resetn(resetn), .req(req), .done(done), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(grant), .busy(busy),
        .plot(plot), .X(X), .Y(Y), .color(color), .timeout(timeout)
    );

    vga_draw_arbiter #(.N_CH(N), .XW(XW), .YW(YW), .CW(CW), .RR_MODE(1), .MAX_HOLD(8)) dut_rr (
        .clock(clock), .resetn(resetn), .req(rr_req), .done(rr_done), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(rr_grant), .busy(rr_busy),
        .plot(rr_plot), .X(rr_X), .Y(rr_Y), .color(rr_color), .timeout(rr_timeout)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Directed sequence covering reset, arbitration, data path, timeout and async reset.
    initial begin
        logic [N-1:0] rr_seq [4];
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

        resetn = 1'b0; req = '0; done = '0; plot_in = '0;
        x_in = '0; y_in = '0; color_in = '0; rr_req = '0; rr_done = '0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_X", 32'(X), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_rr_grant", 32'(rr_grant), 0);
        resetn = 1'b1;
        tick();
        chk("idle_grant", 32'(grant), 0);

        // Round-robin rotation with done after 4 busy cycles and a 1-cycle gap.
        rr_req = 3'b111;
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("rr_grant", 32'(rr_grant), 32'(rr_seq[b]));
            tick(); tick(); tick();
            chk("rr_hold", 32'(rr_grant), 32'(rr_seq[b]));
            rr_done = rr_seq[b];
            tick();
            chk("rr_gap", 32'(rr_grant), 0);
            chk("rr_gap_busy", 32'(rr_busy), 0);
            rr_done = '0;
        end
        rr_req = '0;
        tick();

        // Fixed priority: ch0 first, ch1 only after done[0] plus one idle cycle.
        req = 3'b111;
        tick();
        chk("fix_g0", 32'(grant), 32'(3'b001));
        chk("fix_busy", 32'(busy), 1);
        tick();
        chk("fix_g0_hold", 32'(grant), 32'(3'b001));
        done = 3'b001; req = 3'b110;
        tick();
        chk("fix_rel", 32'(grant), 0);
        done = '0;
        tick();
        chk("fix_g1", 32'(grant), 32'(3'b010));

        // Data path from the owner's slice; ch0's plot_in and slice are ignored.
        plot_in  = 3'b011;
        x_in     = {9'd0, 9'd319, 9'd17};
        y_in     = {8'd0, 8'd239, 8'd5};
        color_in = {3'd0, 3'b101, 3'd2};
        tick();
        chk("dp_plot", 32'(plot), 1);
        chk("dp_X", 32'(X), 319);
        chk("dp_Y", 32'(Y), 239);
        chk("dp_color", 32'(color), 5);
        // Release by done: last pixel still written, then plot drops and X holds.
        done = 3'b010; req = 3'b010;
        tick();
        chk("last_plot", 32'(plot), 1);
        chk("last_grant", 32'(grant), 0);
        done = '0; req = '0; plot_in = '0;
        x_in = {9'd1, 9'd2, 9'd3};
        tick();
        chk("idle_plot", 32'(plot), 0);
        chk("idle_X_hold", 32'(X), 319);

        // Timeout: ch2 holds for 8 busy cycles; ch0 arriving mid-burst waits.
        req = 3'b100;
        tick();
        chk("to_grant", 32'(grant), 32'(3'b100));
        req = 3'b101;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_grant", 32'(grant), 32'(3'b100));
            chk("to_wait_pulse", 32'(timeout), 0);
        end
        tick();
        chk("to_rel_grant", 32'(grant), 0);
        chk("to_pulse", 32'(timeout), 1);
        tick();
        chk("to_pulse_end", 32'(timeout), 0);
        chk("to_next_ch0", 32'(grant), 32'(3'b001));

        // Non-owner done is ignored; done with expiry releases without timeout.
        done = 3'b010;
        tick();
        chk("foreign_done", 32'(grant), 32'(3'b001));
        done = '0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_expiry", 32'(grant), 32'(3'b001));
        done = 3'b001;
        tick();
        chk("done_exp_grant", 32'(grant), 0);
        chk("done_exp_timeout", 32'(timeout), 0);
        done = '0; req = '0;
        tick();

        // Asynchronous reset mid-burst, then fixed mode grants ch0 first.
        req = 3'b010; plot_in = 3'b010;
        tick();
        tick();
        chk("ar_pre_plot", 32'(plot), 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_plot", 32'(plot), 0);
        chk("ar_grant", 32'(grant), 0);
        chk("ar_busy", 32'(busy), 0);
        resetn = 1'b1; req = 3'b011;
        tick();
        chk("ar_after", 32'(grant), 32'(3'b001));
        req = '0; plot_in = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
